alu_req_arbiter: RTL and testbench

- Shares one registered 8-bit ALU between two requesters.
- Round-robin arbitration; accepted operation's operands/opcode driven into the ALU and held for ALU_LAT cycles; result returned on a response channel tagged with requester ID.
- Sits between client logic and the ALU; sole driver of ALU inputs.

---
 rtl/alu_req_arbiter.sv | 217 +++++++++++++++++++++
 tb/tb_alu_req_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_req_arbiter.sv
// Two-requester round-robin front end for a shared registered ALU.
// One operation in flight at a time; the result is returned tagged with the issuing requester.
module alu_req_arbiter #(
  parameter int DW      = 8,
  parameter int SW      = 4,
  parameter int ALU_LAT = 1,
  parameter int CW      = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [DW-1:0] req0_a,
  input  logic [DW-1:0] req0_b,
  input  logic [SW-1:0] req0_sel,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [DW-1:0] req1_a,
  input  logic [DW-1:0] req1_b,
  input  logic [SW-1:0] req1_sel,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [SW-1:0] alu_sel,
  input  logic [DW-1:0] alu_out,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic          rsp_id,
  output logic [DW-1:0] rsp_data,
  output logic          busy,
  output logic [CW-1:0] ops_done
);

  localparam int              CNTW  = 3;
  localparam logic [CNTW-1:0] LAT_C = CNTW'(ALU_LAT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_r;
  state_t          state_next_s;
  logic [CNTW-1:0] cnt_r;
  logic            last_grant_r;
  logic [DW-1:0]   alu_a_r;
  logic [DW-1:0]   alu_b_r;
  logic [SW-1:0]   alu_sel_r;
  logic            rsp_valid_r;
  logic            rsp_id_r;
  logic [DW-1:0]   rsp_data_r;
  logic [CW-1:0]   ops_done_r;

  logic            grant_vld_s;
  logic            grant_id_s;
  logic            transfer_s;
  logic            exec_done_s;
  logic            rsp_hs_s;
  logic [DW-1:0]   win_a_s;
  logic [DW-1:0]   win_b_s;
  logic [SW-1:0]   win_sel_s;

  // Round-robin pick: on a tie the requester that did not win last time gets the grant.
  always_comb begin
    grant_vld_s = 1'b0;
    grant_id_s  = 1'b0;
    if (req0_valid && req1_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = ~last_grant_r;
    end else if (req0_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b0;
    end else if (req1_valid) begin
      grant_vld_s = 1'b1;
      grant_id_s  = 1'b1;
    end else begin
      grant_vld_s = 1'b0;
      grant_id_s  = 1'b0;
    end
  end

  // Handshake qualifiers and the winning requester's operation.
  always_comb begin
    transfer_s  = (state_r == IDLE) && grant_vld_s;
    exec_done_s = (state_r == EXEC) && (cnt_r == LAT_C);
    rsp_hs_s    = (state_r == RESP) && rsp_valid_r && rsp_ready;
    if (grant_id_s) begin
      win_a_s   = req1_a;
      win_b_s   = req1_b;
      win_sel_s = req1_sel;
    end else begin
      win_a_s   = req0_a;
      win_b_s   = req0_b;
      win_sel_s = req0_sel;
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (transfer_s) begin
          state_next_s = EXEC;
        end else begin
          state_next_s = IDLE;
        end
      end
      EXEC: begin
        if (exec_done_s) begin
          state_next_s = RESP;
        end else begin
          state_next_s = EXEC;
        end
      end
      RESP: begin
        if (rsp_hs_s) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = RESP;
        end
      end
      default: begin
        state_next_s = IDLE;
      end
    endcase
  end

  // Output decode: readys only in IDLE and at most one at a time.
  always_comb begin
    req0_ready = transfer_s && !grant_id_s;
    req1_ready = transfer_s && grant_id_s;
    busy       = (state_r != IDLE);
  end

  // Operand capture and grant history; ALU inputs stay at the last issued op until the next transfer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      alu_a_r      <= {DW{1'b0}};
      alu_b_r      <= {DW{1'b0}};
      alu_sel_r    <= {SW{1'b0}};
      rsp_id_r     <= 1'b0;
      last_grant_r <= 1'b1;
    end else if (transfer_s) begin
      alu_a_r      <= win_a_s;
      alu_b_r      <= win_b_s;
      alu_sel_r    <= win_sel_s;
      rsp_id_r     <= grant_id_s;
      last_grant_r <= grant_id_s;
    end else begin
      alu_a_r      <= alu_a_r;
      alu_b_r      <= alu_b_r;
      alu_sel_r    <= alu_sel_r;
      rsp_id_r     <= rsp_id_r;
      last_grant_r <= last_grant_r;
    end
  end

  // Latency counter: cleared on issue, counts every EXEC edge until the ALU result is due.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_r <= {CNTW{1'b0}};
    end else if (transfer_s) begin
      cnt_r <= {CNTW{1'b0}};
    end else if (state_r == EXEC) begin
      cnt_r <= cnt_r + {{(CNTW-1){1'b0}}, 1'b1};
    end else begin
      cnt_r <= cnt_r;
    end
  end

  // Response channel: capture the ALU result, hold it until the consumer takes it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DW{1'b0}};
    end else if (exec_done_s) begin
      rsp_valid_r <= 1'b1;
      rsp_data_r  <= alu_out;
    end else if (rsp_hs_s) begin
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= rsp_data_r;
    end else begin
      rsp_valid_r <= rsp_valid_r;
      rsp_data_r  <= rsp_data_r;
    end
  end

  // Completed-response counter, free-running wrap.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ops_done_r <= {CW{1'b0}};
    end else if (rsp_hs_s) begin
      ops_done_r <= ops_done_r + {{(CW-1){1'b0}}, 1'b1};
    end else begin
      ops_done_r <= ops_done_r;
    end
  end

  assign alu_a     = alu_a_r;
  assign alu_b     = alu_b_r;
  assign alu_sel   = alu_sel_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_id    = rsp_id_r;
  assign rsp_data  = rsp_data_r;
  assign ops_done  = ops_done_r;

endmodule

// File: tb/tb_alu_req_arbiter.sv
// Directed bench for alu_req_arbiter with a registered ALU stub (ALU_LAT=1);
// a second CW=4 instance shares the stimulus to exercise counter wrap.
module tb_alu_req_arbiter;

  logic       clk;
  logic       rst;
  logic       req0_valid, req1_valid, rsp_ready;
  logic [7:0] req0_a, req0_b, req1_a, req1_b;
  logic [3:0] req0_sel, req1_sel;

  logic       req0_ready, req1_ready, rsp_valid, rsp_id, busy;
  logic [7:0] alu_a, alu_b, alu_out, rsp_data;
  logic [3:0] alu_sel;
  logic [15:0] ops_done;

  logic       req0_ready4, req1_ready4, rsp_valid4, rsp_id4, busy4;
  logic [7:0] alu_a4, alu_b4, alu_out4, rsp_data4;
  logic [3:0] alu_sel4;
  logic [3:0] ops_done4;

  int n_chk;
  int n_fail;
  logic [7:0] exp_tab [16];

  alu_req_arbiter #(.DW(8), .SW(4), .ALU_LAT(1), .CW(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_out(alu_out),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .busy(busy), .ops_done(ops_done)
  );

  alu_req_arbiter #(.DW(8), .SW(4), .ALU_LAT(1), .CW(4)) dut4 (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready4), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
    .req1_valid(req1_valid), .req1_ready(req1_ready4), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
    .alu_a(alu_a4), .alu_b(alu_b4), .alu_sel(alu_sel4), .alu_out(alu_out4),
    .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready), .rsp_id(rsp_id4), .rsp_data(rsp_data4),
    .busy(busy4), .ops_done(ops_done4)
  );

  function automatic logic [7:0] stub(input logic [7:0] a, input logic [7:0] b, input logic [3:0] sel);
    case (sel)
      4'd0:    stub = a + b;
      4'd1:    stub = a - b;
      4'd2:    stub = a & b;
      4'd3:    stub = a | b;
      4'd4:    stub = a ^ b;
      4'd5:    stub = ~a;
      4'd6:    stub = a << 1;
      4'd7:    stub = a >> 1;
      4'd8:    stub = b;
      default: stub = a;
    endcase
  endfunction

  always_ff @(posedge clk) begin
    alu_out  <= stub(alu_a, alu_b, alu_sel);
    alu_out4 <= stub(alu_a4, alu_b4, alu_sel4);
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk = n_chk + 1;
    assert (obs === exp) else begin
      n_fail = n_fail + 1;
      $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
    end
  endtask

  initial begin
    n_chk = 0;
    n_fail = 0;
    exp_tab = '{8'hD1, 8'h91, 8'h20, 8'hB1, 8'h91, 8'h4E, 8'h62, 8'h58,
                8'h20, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1, 8'hB1};
    rst = 1'b1;
    req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
    req0_a = 8'h00; req0_b = 8'h00; req0_sel = 4'h0;
    req1_a = 8'h00; req1_b = 8'h00; req1_sel = 4'h0;

    // reset state
    tick(); tick();
    chk("rst_alu_a", 32'(alu_a), 32'h0);
    chk("rst_alu_b", 32'(alu_b), 32'h0);
    chk("rst_alu_sel", 32'(alu_sel), 32'h0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_id", 32'(rsp_id), 32'h0);
    chk("rst_rsp_data", 32'(rsp_data), 32'h0);
    chk("rst_ops_done", 32'(ops_done), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_ops_done4", 32'(ops_done4), 32'h0);
    rst = 1'b0;
    rsp_ready = 1'b1;
    tick();

    // single op from requester 0
    req0_valid = 1'b1; req0_a = 8'hB1; req0_b = 8'h20; req0_sel = 4'd0;
    #1;
    chk("single_rdy0", 32'(req0_ready), 32'h1);
    chk("single_rdy1", 32'(req1_ready), 32'h0);
    tick();
    req0_valid = 1'b0; req0_a = 8'h00;
    #1;
    chk("single_rdy0_t1", 32'(req0_ready), 32'h0);
    chk("single_alu_a", 32'(alu_a), 32'hB1);
    chk("single_alu_b", 32'(alu_b), 32'h20);
    chk("single_alu_sel", 32'(alu_sel), 32'h0);
    chk("single_busy", 32'(busy), 32'h1);
    chk("single_rv_t1", 32'(rsp_valid), 32'h0);
    tick();
    chk("single_rv_t2", 32'(rsp_valid), 32'h0);
    tick();
    chk("single_rv_t3", 32'(rsp_valid), 32'h1);
    chk("single_data", 32'(rsp_data), 32'hD1);
    chk("single_id", 32'(rsp_id), 32'h0);
    chk("single_ops_t3", 32'(ops_done), 32'h0);
    tick();
    chk("single_rv_t4", 32'(rsp_valid), 32'h0);
    chk("single_ops", 32'(ops_done), 32'h1);
    chk("single_idle", 32'(busy), 32'h0);
    chk("single_alu_hold", 32'(alu_a), 32'hB1);

    // reset asserted mid-EXEC takes effect without a clock edge
    req1_valid = 1'b1; req1_a = 8'h77; req1_b = 8'h11; req1_sel = 4'd3;
    #1;
    chk("midrst_rdy1", 32'(req1_ready), 32'h1);
    tick();
    req1_valid = 1'b0;
    chk("midrst_busy", 32'(busy), 32'h1);
    chk("midrst_alu_a", 32'(alu_a), 32'h77);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_alu_a0", 32'(alu_a), 32'h0);
    chk("midrst_alu_b0", 32'(alu_b), 32'h0);
    chk("midrst_alu_sel0", 32'(alu_sel), 32'h0);
    chk("midrst_busy0", 32'(busy), 32'h0);
    chk("midrst_rv0", 32'(rsp_valid), 32'h0);
    chk("midrst_id0", 32'(rsp_id), 32'h0);
    chk("midrst_ops0", 32'(ops_done), 32'h0);
    tick(); tick();
    chk("midrst_rv_hold", 32'(rsp_valid), 32'h0);
    chk("midrst_ops_hold", 32'(ops_done), 32'h0);

    // tie + round robin after reset: req0 first
    rst = 1'b0;
    req0_valid = 1'b1; req0_a = 8'h05; req0_b = 8'h03; req0_sel = 4'd1;
    req1_valid = 1'b1; req1_a = 8'hF0; req1_b = 8'h3C; req1_sel = 4'd2;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_rdy0", 32'(req0_ready), (k % 2 == 0) ? 32'h1 : 32'h0);
      chk("rr_rdy1", 32'(req1_ready), (k % 2 == 0) ? 32'h0 : 32'h1);
      tick();
      chk("rr_exec_rdy", 32'({req0_ready, req1_ready}), 32'h0);
      tick(); tick();
      chk("rr_rv", 32'(rsp_valid), 32'h1);
      chk("rr_id", 32'(rsp_id), (k % 2 == 0) ? 32'h0 : 32'h1);
      chk("rr_data", 32'(rsp_data), (k % 2 == 0) ? 32'h02 : 32'h30);
      chk("rr_resp_rdy", 32'({req0_ready, req1_ready}), 32'h0);
      chk("rr_ops", 32'(ops_done), 32'(k));
      tick();
      if (k == 3) begin
        req0_valid = 1'b0;
        req1_valid = 1'b0;
      end
    end
    #1;
    chk("rr_ops_end", 32'(ops_done), 32'h4);
    chk("rr_idle", 32'(busy), 32'h0);
    chk("rr_idle_rdy", 32'({req0_ready, req1_ready}), 32'h0);

    // response backpressure
    tick();
    rsp_ready = 1'b0;
    req0_valid = 1'b1;
    #1;
    chk("bp_rdy0", 32'(req0_ready), 32'h1);
    tick();
    req0_valid = 1'b0;
    req1_valid = 1'b1;
    tick(); tick();
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("bp_rv", 32'(rsp_valid), 32'h1);
      chk("bp_data", 32'(rsp_data), 32'h02);
      chk("bp_id", 32'(rsp_id), 32'h0);
      chk("bp_busy", 32'(busy), 32'h1);
      chk("bp_rdy", 32'({req0_ready, req1_ready}), 32'h0);
      tick();
    end
    req1_valid = 1'b0;
    rsp_ready = 1'b1;
    #1;
    chk("bp_rv_last", 32'(rsp_valid), 32'h1);
    tick();
    chk("bp_rv_done", 32'(rsp_valid), 32'h0);
    chk("bp_idle", 32'(busy), 32'h0);
    chk("bp_ops", 32'(ops_done), 32'h5);

    // reset pulse, then opcode sweep from requester 1
    rst = 1'b1;
    #1;
    chk("pulse_ops", 32'(ops_done), 32'h0);
    chk("pulse_ops4", 32'(ops_done4), 32'h0);
    tick();
    rst = 1'b0;
    for (int s = 0; s < 16; s++) begin
      req1_valid = 1'b1; req1_a = 8'hB1; req1_b = 8'h20; req1_sel = 4'(s);
      #1;
      chk("sw_rdy1", 32'(req1_ready), 32'h1);
      chk("sw_rdy0", 32'(req0_ready), 32'h0);
      chk("sw4_rdy", 32'({req0_ready4, req1_ready4}), 32'h1);
      tick();
      req1_valid = 1'b0;
      chk("sw_alu_sel", 32'(alu_sel), 32'(s));
      chk("sw4_busy", 32'(busy4), 32'h1);
      tick(); tick();
      chk("sw_rv", 32'(rsp_valid), 32'h1);
      chk("sw_data", 32'(rsp_data), 32'(exp_tab[s]));
      chk("sw_id", 32'(rsp_id), 32'h1);
      chk("sw4_rv", 32'(rsp_valid4), 32'h1);
      chk("sw4_data", 32'(rsp_data4), 32'(exp_tab[s]));
      chk("sw4_id", 32'(rsp_id4), 32'h1);
      tick();
    end
    #1;
    chk("sw_ops", 32'(ops_done), 32'h10);
    chk("sw_ops4_wrap", 32'(ops_done4), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
